// File: rtl/axi3_sram_slave.sv
// AXI3 slave backed by a 2**MEM_AW x 32b word SRAM; independent read/write engines, 1 beat/cycle.
// Optional AXI_SLV_DECERR_EN: out-of-range addresses return DECERR instead of aliasing.
module axi3_sram_slave #(
  parameter int    MEM_AW   = 12,
  parameter string INIT_HEX = ""
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  // WRAP is deliberately treated as INCR
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bt);
    return (bt == BURST_FIXED) ? a : a + (32'd1 << sz);
  endfunction

  function automatic logic [MEM_AW-1:0] widx(input logic [31:0] a);
    return a[MEM_AW+1:2];
  endfunction

  logic ar_dec, aw_dec;
`ifdef AXI_SLV_DECERR_EN
  assign ar_dec = |araddr[31:MEM_AW+2];
  assign aw_dec = |awaddr[31:MEM_AW+2];
`else
  assign ar_dec = 1'b0;
  assign aw_dec = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // ---------------- read engine ----------------
  r_state_t    r_state;
  logic [31:0] r_addr, r_nxt;
  logic [3:0]  r_len, r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_dec;

  assign r_nxt = next_addr(r_addr, r_size, r_burst);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      rdata   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_dec   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_state <= R_DATA;
          arready <= 1'b0;
          rvalid  <= 1'b1;
          rid     <= arid;
          r_addr  <= araddr;
          r_len   <= arlen;
          r_size  <= arsize;
          r_burst <= arburst;
          r_beat  <= '0;
          r_dec   <= ar_dec;
          rdata   <= ar_dec ? 32'd0 : mem[widx(araddr)];
          rresp   <= ar_dec ? RESP_DECERR : RESP_OKAY;
          rlast   <= (arlen == 4'd0);
        end
        R_DATA: if (rready) begin
          if (rlast) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
          end else begin
            r_addr <= r_nxt;
            rdata  <= r_dec ? 32'd0 : mem[widx(r_nxt)];
            r_beat <= r_beat + 4'd1;
            rlast  <= (r_beat + 4'd1 == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write engine ----------------
  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [3:0]  w_len, w_beat;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_dec, w_err, w_last_beat, w_err_now, mem_we;

  assign w_last_beat = (w_beat == w_len);
  assign w_err_now   = w_err | (wlast != w_last_beat);
  assign mem_we      = (w_state == W_DATA) && wvalid && !w_dec;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_dec   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          w_state <= W_DATA;
          awready <= 1'b0;
          wready  <= 1'b1;
          bid     <= awid;
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_size  <= awsize;
          w_burst <= awburst;
          w_beat  <= '0;
          w_dec   <= aw_dec;
          w_err   <= 1'b0;
        end
        // burst length comes from awlen; a misplaced wlast only flags SLVERR
        W_DATA: if (wvalid) begin
          if (w_last_beat) begin
            w_state <= W_RESP;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= w_dec ? RESP_DECERR : (w_err_now ? RESP_SLVERR : RESP_OKAY);
          end else begin
            w_err  <= w_err_now;
            w_addr <= next_addr(w_addr, w_size, w_burst);
            w_beat <= w_beat + 4'd1;
          end
        end
        W_RESP: if (bready) begin
          w_state <= W_IDLE;
          bvalid  <= 1'b0;
          awready <= 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // SRAM array is not reset; same-cycle read of this word sees the old value
  always_ff @(posedge aclk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[widx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
  end

endmodule

// File: tb/tb_axi3_sram_slave.sv
// Scoreboard bench for axi3_sram_slave: word-model memory predicts every R beat and B response.
module tb_axi3_sram_slave;
  logic        aclk, aresetn;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi3_sram_slave #(.MEM_AW(12)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arlock(arlock), .arcache(arcache), .arprot(arprot), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awlock(awlock), .awcache(awcache), .awprot(awprot), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
    logic [1:0]  resp;
  } rexp_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] mdl [int];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];
  int          n_chk = 0, n_pass = 0;

  localparam logic [1:0] INCR = 2'b01, FIXED = 2'b00;

  task automatic step();
    @(posedge aclk); #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  function automatic logic is_dec(input logic [31:0] a);
`ifdef AXI_SLV_DECERR_EN
    return |a[31:14];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] mget(input logic [31:0] a);
    return mdl.exists(widx(a)) ? mdl[widx(a)] : 32'd0;
  endfunction

  // ---- read transaction: predict beats into rq, then drain and compare ----
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input logic [1:0] burst, input bit stall);
    logic [31:0] a, held;
    rexp_t       e;
    bit          held_v;
    int          t, got, cyc;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = is_dec(addr) ? 32'd0 : mget(a);
      e.id   = id;
      e.last = (i == int'(len));
      e.resp = is_dec(addr) ? 2'b11 : 2'b00;
      rq.push_back(e);
      if (burst != FIXED) a = a + 32'd4;
    end
    araddr = addr; arlen = len; arid = id; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin step(); t++; end
    n_chk++;
    if (!arready) $display("FAIL ar_timeout: arready=%b required 1", arready);
    else n_pass++;
    step();
    arvalid = 1'b0;
    got = 0; cyc = 0; held_v = 0; held = '0;
    while (got <= int'(len) && cyc < 100) begin
      rready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      if (held_v && rvalid) begin
        n_chk++;
        if (rdata !== held) $display("FAIL r_hold: rdata=%h required %h", rdata, held);
        else n_pass++;
      end
      if (rvalid && rready) begin
        e = (rq.size() > 0) ? rq.pop_front() : '0;
        n_chk++;
        if ({rdata, rid, rlast, rresp} !== e)
          $display("FAIL r_beat: got data=%h id=%h last=%b resp=%b required data=%h id=%h last=%b resp=%b",
                   rdata, rid, rlast, rresp, e.data, e.id, e.last, e.resp);
        else n_pass++;
        got++; held_v = 0;
      end else if (rvalid) begin
        held = rdata; held_v = 1;
      end
      step(); cyc++;
    end
    rready = 1'b0;
    n_chk++;
    if (got <= int'(len) || rvalid !== 1'b0)
      $display("FAIL r_count: beats=%0d rvalid_after=%b required beats=%0d rvalid_after=0",
               got, rvalid, int'(len) + 1);
    else n_pass++;
    rq.delete();
  endtask

  // ---- write transaction from wd/ws/wl; model memory and B predicted up front ----
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                           input logic [1:0] burst);
    logic [31:0] a, v;
    bexp_t       e;
    bit          err;
    int          t;
    a = addr; err = 0;
    for (int i = 0; i <= int'(len); i++) begin
      if (wl[i] != (i == int'(len))) err = 1;
      if (!is_dec(addr)) begin
        v = mget(a);
        for (int b = 0; b < 4; b++) if (ws[i][b]) v[8*b +: 8] = wd[i][8*b +: 8];
        mdl[widx(a)] = v;
      end
      if (burst != FIXED) a = a + 32'd4;
    end
    e.id = id;
    e.resp = is_dec(addr) ? 2'b11 : (err ? 2'b10 : 2'b00);
    bq.push_back(e);
    awaddr = addr; awlen = len; awid = id; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin step(); t++; end
    step();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin step(); t++; end
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin step(); t++; end
    e = bq.pop_front();
    n_chk++;
    if ({bvalid, bid, bresp} !== {1'b1, e})
      $display("FAIL b_resp: bvalid=%b bid=%h bresp=%b required bvalid=1 bid=%h bresp=%b",
               bvalid, bid, bresp, e.id, e.resp);
    else n_pass++;
    step();
    bready = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base, input logic [31:0] inc, input int n);
    for (int i = 0; i < 16; i++) begin
      wd[i] = base + inc * i;
      ws[i] = 4'hF;
      wl[i] = (i == n - 1);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    step(); step();
    n_chk++;
    if ({arready, awready, wready, rvalid, rlast, rresp, rid, rdata, bvalid, bresp, bid} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'h0, 1'b0, 2'b00, 4'h0})
      $display("FAIL reset_state: ar=%b aw=%b w=%b rv=%b rl=%b rr=%b rid=%h rd=%h bv=%b br=%b bid=%h required 1 1 0 0 0 00 0 0 0 00 0",
               arready, awready, wready, rvalid, rlast, rresp, rid, rdata, bvalid, bresp, bid);
    else n_pass++;
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_incr_burst();
    fill(32'h11, 32'h11, 4);
    axi_write(32'h100, 4'd3, 4'd3, INCR);
    axi_read(32'h100, 4'd3, 4'd5, INCR, 0);
  endtask

  task automatic test_strobes();
    fill(32'hAABBCCDD, 0, 1);
    axi_write(32'h8, 4'd0, 4'd1, INCR);
    fill(32'h00001122, 0, 1);
    ws[0] = 4'b0011;
    axi_write(32'h8, 4'd0, 4'd1, INCR);
    axi_read(32'h8, 4'd0, 4'd2, INCR, 0);
  endtask

  task automatic test_stall_fixed();
    axi_read(32'h100, 4'd3, 4'd6, INCR, 1);
    fill(32'h2020_0000, 1, 1);
    axi_write(32'h20, 4'd0, 4'd4, INCR);
    fill(32'h2424_0000, 1, 1);
    axi_write(32'h24, 4'd0, 4'd4, INCR);
    axi_read(32'h20, 4'd2, 4'd7, FIXED, 0);
  endtask

  task automatic test_wlast_err();
    fill(32'h5000_0001, 1, 3);
    wl[0] = 1'b1; wl[1] = 1'b0; wl[2] = 1'b0;
    axi_write(32'h200, 4'd2, 4'd9, INCR);
    axi_read(32'h200, 4'd2, 4'd9, INCR, 0);
  endtask

  task automatic test_reset_mid_burst();
    fill(32'hCAFE0040, 0, 1);
    axi_write(32'h40, 4'd0, 4'd2, INCR);
    fill(32'h5151_0000, 1, 4);
    axi_write(32'h50, 4'd3, 4'd2, INCR);
    araddr = 32'h50; arlen = 4'd3; arid = 4'd1; arburst = INCR; arsize = 3'd2; arvalid = 1'b1;
    step();
    arvalid = 1'b0; rready = 1'b1;
    n_chk++;
    if ({rvalid, rdata} !== {1'b1, mget(32'h50)})
      $display("FAIL rst_beat1: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, mget(32'h50));
    else n_pass++;
    step();
    rready = 1'b0;
    aresetn = 1'b0;
    #1;
    n_chk++;
    if ({rvalid, arready, rlast} !== 3'b010)
      $display("FAIL rst_mid: rvalid=%b arready=%b rlast=%b required 0 1 0", rvalid, arready, rlast);
    else n_pass++;
    step(); step();
    aresetn = 1'b1;
    step();
    axi_read(32'h40, 4'd0, 4'd8, INCR, 0);
  endtask

  task automatic test_decode();
    fill(32'h0000_AAAA, 1, 2);
    axi_write(32'h0, 4'd1, 4'd1, INCR);
    axi_read(32'h8000_0000, 4'd1, 4'd2, INCR, 0);
    fill(32'h5A5A_5A5A, 0, 1);
    axi_write(32'h8000_0000, 4'd0, 4'd3, INCR);
    axi_read(32'h0, 4'd0, 4'd4, INCR, 0);
  endtask

  task automatic test_back_to_back();
    axi_read(32'h104, 4'd1, 4'd10, INCR, 0);
    axi_read(32'h200, 4'd0, 4'd11, INCR, 0);
  endtask

  initial begin
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = INCR; arvalid = 1'b0;
    arlock = '0; arcache = '0; arprot = '0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = INCR; awvalid = 1'b0;
    awlock = '0; awcache = '0; awprot = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    test_reset();
    test_incr_burst();
    test_strobes();
    test_stall_fixed();
    test_wlast_err();
    test_reset_mid_burst();
    test_decode();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
